// File: rtl/mc_controller.sv
// Multicycle control FSM: sequences each instruction through fetch, decode,
// execute, memory and writeback states, drives the datapath selects and write
// enables, and waits out a fixed-latency memory with a small wait counter.
module mc_controller #(
  parameter int MEM_LAT = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] op,
  input  logic       Zero,
  output logic [2:0] ALUControl,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] result_src,
  output logic       adr_src,
  output logic       ir_write,
  output logic       pc_write,
  output logic       reg_write,
  output logic       mem_write,
  output logic       illegal,
  output logic [3:0] state_o
);

  localparam int CW = $clog2(MEM_LAT + 1);

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMREAD  = 4'd3,
    MEMWB    = 4'd4,
    MEMWRITE = 4'd5,
    EXEC_R   = 4'd6,
    EXEC_I   = 4'd7,
    ALUWB    = 4'd8,
    BRANCH   = 4'd9
  } state_t;

  state_t        state;
  state_t        state_next;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_next;
  logic          last;
  logic          ir_w;
  logic          pc_w;
  logic          reg_w;
  logic          mem_w;
  logic          ill;

  assign last    = (cnt == CW'(MEM_LAT - 1));
  assign state_o = state;

  // Enables are suppressed while reset is held so an abandoned instruction
  // cannot write anything.
  assign ir_write  = ir_w  & ~reset;
  assign pc_write  = pc_w  & ~reset;
  assign reg_write = reg_w & ~reset;
  assign mem_write = mem_w & ~reset;
  assign illegal   = ill   & ~reset;

  // State register and memory wait counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= FETCH;
      cnt   <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  // Next-state, Moore output decode (plus Zero in BRANCH) and counter update.
  always_comb begin
    state_next = state;
    ALUControl = 3'b000;
    alu_src_a  = 1'b0;
    alu_src_b  = 2'b00;
    result_src = 2'b00;
    adr_src    = 1'b0;
    ir_w       = 1'b0;
    pc_w       = 1'b0;
    reg_w      = 1'b0;
    mem_w      = 1'b0;
    ill        = 1'b0;
    cnt_next   = '0;

    case (state)
      FETCH: begin
        alu_src_b  = 2'b10;
        result_src = 2'b10;
        if (last) begin
          ir_w       = 1'b1;
          pc_w       = 1'b1;
          state_next = DECODE;
        end
      end
      DECODE: begin
        alu_src_b = 2'b01;
        case (op)
          4'b0000, 4'b0001, 4'b0010,
          4'b0011, 4'b0100, 4'b0101: state_next = EXEC_R;
          4'b1000:                   state_next = EXEC_I;
          4'b1001, 4'b1010:          state_next = MEMADR;
          4'b1100, 4'b1101:          state_next = BRANCH;
          default: begin
            ill        = 1'b1;
            state_next = FETCH;
          end
        endcase
      end
      EXEC_R: begin
        alu_src_a  = 1'b1;
        ALUControl = op[2:0];
        state_next = ALUWB;
      end
      EXEC_I: begin
        alu_src_a  = 1'b1;
        alu_src_b  = 2'b01;
        state_next = ALUWB;
      end
      ALUWB: begin
        reg_w      = 1'b1;
        state_next = FETCH;
      end
      MEMADR: begin
        alu_src_a  = 1'b1;
        alu_src_b  = 2'b01;
        state_next = (op == 4'b1001) ? MEMREAD : MEMWRITE;
      end
      MEMREAD: begin
        adr_src = 1'b1;
        if (last) state_next = MEMWB;
      end
      MEMWB: begin
        result_src = 2'b01;
        reg_w      = 1'b1;
        state_next = FETCH;
      end
      MEMWRITE: begin
        adr_src = 1'b1;
        mem_w   = 1'b1;
        if (last) state_next = FETCH;
      end
      BRANCH: begin
        alu_src_a  = 1'b1;
        ALUControl = 3'b001;
        pc_w       = (op == 4'b1101) ? 1'b1 : Zero;
        state_next = FETCH;
      end
      default: state_next = FETCH;
    endcase

    if (state_next == state &&
        (state == FETCH || state == MEMREAD || state == MEMWRITE))
      cnt_next = cnt + CW'(1);
  end

endmodule

// File: tb/tb_mc_controller.sv
// Testbench for mc_controller: two instances (memory latency 1 and 3) are
// driven with directed and random opcodes and compared cycle by cycle against
// an instruction-level reference model that lists the expected output vector
// for every cycle of each instruction.
module tb_mc_controller;

  logic clk;

  logic       reset_a, zero_a;
  logic [3:0] op_a, state_a;
  logic [2:0] alu_a;
  logic       sa_a, adr_a, ir_a, pc_a, rw_a, mw_a, ill_a;
  logic [1:0] sb_a, rs_a;

  logic       reset_b, zero_b;
  logic [3:0] op_b, state_b;
  logic [2:0] alu_b;
  logic       sa_b, adr_b, ir_b, pc_b, rw_b, mw_b, ill_b;
  logic [1:0] sb_b, rs_b;

  logic [17:0] obs_a, obs_b;
  logic [17:0] expq[$];

  int checks = 0;
  int errors = 0;

  localparam logic [17:0] MASK_ALL = 18'h3FFFF;
  localparam logic [17:0] MASK_RST = 18'h3C01F;

  mc_controller #(.MEM_LAT(1)) dut_a (
    .clk(clk), .reset(reset_a), .op(op_a), .Zero(zero_a),
    .ALUControl(alu_a), .alu_src_a(sa_a), .alu_src_b(sb_a),
    .result_src(rs_a), .adr_src(adr_a), .ir_write(ir_a),
    .pc_write(pc_a), .reg_write(rw_a), .mem_write(mw_a),
    .illegal(ill_a), .state_o(state_a)
  );

  mc_controller #(.MEM_LAT(3)) dut_b (
    .clk(clk), .reset(reset_b), .op(op_b), .Zero(zero_b),
    .ALUControl(alu_b), .alu_src_a(sa_b), .alu_src_b(sb_b),
    .result_src(rs_b), .adr_src(adr_b), .ir_write(ir_b),
    .pc_write(pc_b), .reg_write(rw_b), .mem_write(mw_b),
    .illegal(ill_b), .state_o(state_b)
  );

  assign obs_a = {state_a, alu_a, sa_a, sb_a, rs_a, adr_a, ir_a, pc_a, rw_a, mw_a, ill_a};
  assign obs_b = {state_b, alu_b, sa_b, sb_b, rs_b, adr_b, ir_b, pc_b, rw_b, mw_b, ill_b};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Append one expected cycle to the reference queue.
  function automatic void addStep(input int st, input logic [2:0] alu, input logic sa,
                                  input logic [1:0] sb, input logic [1:0] rs, input logic adr,
                                  input logic irw, input logic pcw, input logic rw,
                                  input logic mw, input logic ill);
    expq.push_back({4'(st), alu, sa, sb, rs, adr, irw, pcw, rw, mw, ill});
  endfunction

  // Expected cycle list for one whole instruction, built from the opcode rules.
  function automatic void buildSeq(input int lat, input logic [3:0] op, input logic zero);
    expq.delete();
    for (int i = 0; i < lat; i++) begin
      logic lst;
      lst = (i == lat - 1);
      addStep(0, 3'd0, 1'b0, 2'b10, 2'b10, 1'b0, lst, lst, 1'b0, 1'b0, 1'b0);
    end
    if (op <= 4'd5) begin
      addStep(1, 3'd0, 1'b0, 2'b01, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      addStep(6, op[2:0], 1'b1, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      addStep(8, 3'd0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    end else if (op == 4'd8) begin
      addStep(1, 3'd0, 1'b0, 2'b01, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      addStep(7, 3'd0, 1'b1, 2'b01, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      addStep(8, 3'd0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    end else if (op == 4'd9) begin
      addStep(1, 3'd0, 1'b0, 2'b01, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      addStep(2, 3'd0, 1'b1, 2'b01, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < lat; i++)
        addStep(3, 3'd0, 1'b0, 2'b00, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      addStep(4, 3'd0, 1'b0, 2'b00, 2'b01, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    end else if (op == 4'd10) begin
      addStep(1, 3'd0, 1'b0, 2'b01, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      addStep(2, 3'd0, 1'b1, 2'b01, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < lat; i++)
        addStep(5, 3'd0, 1'b0, 2'b00, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    end else if (op == 4'd12 || op == 4'd13) begin
      addStep(1, 3'd0, 1'b0, 2'b01, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      addStep(9, 3'b001, 1'b1, 2'b00, 2'b00, 1'b0, 1'b0,
              (op == 4'd13) ? 1'b1 : zero, 1'b0, 1'b0, 1'b0);
    end else begin
      addStep(1, 3'd0, 1'b0, 2'b01, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    end
  endfunction

  // Drive the opcode and Zero flag of the selected instance.
  task automatic applyStimulus(input bit sel, input logic [3:0] op, input logic zero);
    if (sel) begin op_b = op; zero_b = zero; end
    else     begin op_a = op; zero_a = zero; end
  endtask

  task automatic setReset(input bit sel, input logic val);
    if (sel) reset_b = val;
    else     reset_a = val;
  endtask

  // Compare the masked output vector of the selected instance.
  task automatic checkOutput(input bit sel, input string tag, input logic [17:0] mask,
                             input logic [17:0] expv);
    logic [17:0] o;
    o = sel ? obs_b : obs_a;
    checks++;
    assert ((o & mask) === (expv & mask))
    else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, o & mask, expv & mask);
    end
  endtask

  // Walk the first n reference cycles, checking at the falling edge.
  task automatic runSteps(input bit sel, input logic [3:0] op, input logic zero, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      checkOutput(sel, $sformatf("dut%0d_op%b_z%0d_cyc%0d", sel, op, zero, i), MASK_ALL, expq[i]);
      @(posedge clk);
      #1;
    end
  endtask

  task automatic runInstr(input bit sel, input logic [3:0] op, input logic zero);
    applyStimulus(sel, op, zero);
    buildSeq(sel ? 3 : 1, op, zero);
    runSteps(sel, op, zero, expq.size());
  endtask

  // Abandon an instruction after k cycles with reset held for 'hold' cycles.
  task automatic resetDuring(input bit sel, input logic [3:0] op, input logic zero,
                             input int k, input int hold);
    logic [3:0] st;
    applyStimulus(sel, op, zero);
    buildSeq(sel ? 3 : 1, op, zero);
    runSteps(sel, op, zero, k);
    setReset(sel, 1'b1);
    for (int h = 0; h < hold; h++) begin
      st = (h == 0) ? expq[k][17:14] : 4'd0;
      @(negedge clk);
      checkOutput(sel, $sformatf("dut%0d_reset_k%0d_h%0d", sel, k, h), MASK_RST, {st, 14'd0});
      @(posedge clk);
      #1;
    end
    setReset(sel, 1'b0);
  endtask

  initial begin
    logic [3:0] rop;
    logic       rz;
    reset_a = 1'b1; reset_b = 1'b1;
    op_a = 4'd0; op_b = 4'd0; zero_a = 1'b0; zero_b = 1'b0;
    repeat (3) @(posedge clk);
    #1;

    @(negedge clk);
    checkOutput(1'b0, "reset_state_a", MASK_RST, 18'd0);
    checkOutput(1'b1, "reset_state_b", MASK_RST, 18'd0);
    @(posedge clk);
    #1;
    reset_a = 1'b0;

    runInstr(1'b0, 4'b0000, 1'b0);
    runInstr(1'b0, 4'b0101, 1'b0);
    runInstr(1'b0, 4'b1010, 1'b0);
    runInstr(1'b0, 4'b1001, 1'b1);
    runInstr(1'b0, 4'b1000, 1'b0);
    runInstr(1'b0, 4'b1100, 1'b1);
    runInstr(1'b0, 4'b1100, 1'b0);
    runInstr(1'b0, 4'b1101, 1'b0);
    runInstr(1'b0, 4'b1111, 1'b0);
    runInstr(1'b0, 4'b0011, 1'b1);
    resetDuring(1'b0, 4'b1010, 1'b0, 3, 2);
    runInstr(1'b0, 4'b0010, 1'b0);
    for (int n = 0; n < 40; n++) begin
      rop = 4'($urandom_range(0, 15));
      rz  = 1'($urandom_range(0, 1));
      runInstr(1'b0, rop, rz);
    end
    reset_a = 1'b1;

    reset_b = 1'b0;
    runInstr(1'b1, 4'b1001, 1'b0);
    resetDuring(1'b1, 4'b1001, 1'b0, 5, 2);
    runInstr(1'b1, 4'b0001, 1'b0);
    resetDuring(1'b1, 4'b0100, 1'b0, 2, 2);
    runInstr(1'b1, 4'b1010, 1'b1);
    runInstr(1'b1, 4'b0110, 1'b0);
    for (int n = 0; n < 30; n++) begin
      rop = 4'($urandom_range(0, 15));
      rz  = 1'($urandom_range(0, 1));
      runInstr(1'b1, rop, rz);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
